// File: rtl/sipo_frame_rx_if.sv
// Bundles the serial input, the consumer handshake and the receiver status
// for sipo_frame_rx; slave is the receiver, master the line driver/consumer.
interface sipo_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             out_ready;
  logic [WIDTH-1:0] pout;
  logic             out_valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport master (
    output sin,
    output out_ready,
    input  pout,
    input  out_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );

  modport slave (
    input  sin,
    input  out_ready,
    output pout,
    output out_valid,
    output frame_err,
    output overrun,
    output busy
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver: start(1), WIDTH bits MSB first, stop(0); word valid WIDTH+1 edges after start.
// One-word holding register: a good frame arriving while the word is unconsumed is dropped and flags sticky overrun.
module sipo_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  sipo_frame_rx_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_pout;
  logic             r_out_valid;
  logic             r_frame_err;
  logic             r_overrun;
  logic             r_busy;

  logic             w_last_bit;
  logic             w_stop_good;
  logic             w_stop_bad;
  logic             w_load;
  logic             w_drop;
  logic             w_accept;

  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sin) begin
          w_next_state = DATA;
        end
      end
      DATA: begin
        if (w_last_bit) begin
          w_next_state = STOP;
        end
      end
      STOP: begin
        // The next start bit may follow immediately, so STOP always exits to IDLE.
        w_next_state = IDLE;
        w_stop_good  = ~bus.sin;
        w_stop_bad   = bus.sin;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_accept = r_out_valid & bus.out_ready;
  assign w_load   = w_stop_good & (~r_out_valid | bus.out_ready);
  assign w_drop   = w_stop_good & r_out_valid & ~bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_pout      <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy      <= (w_next_state != IDLE);
      r_frame_err <= w_stop_bad;

      // Counter parks on the last index instead of wrapping when WIDTH is a power of two.
      if (r_state == IDLE && bus.sin) begin
        r_cnt <= '0;
      end else if (r_state == DATA && !w_last_bit) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (r_state == DATA) begin
        r_shreg <= {r_shreg[WIDTH-2:0], bus.sin};
      end

      if (w_load) begin
        r_pout      <= r_shreg;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.pout      = r_pout;
  assign bus.out_valid = r_out_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = r_busy;

endmodule

// File: doc/sipo_frame_rx.md
SIPO_FRAME_RX -- requirements
Module: sipo_frame_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sin  input  1  serial line, sampled once per rising clk edge; idle level 0.
REQ-005 SHALL have port out_ready  input  1  consumer accepts pout when high together with out_valid.
REQ-006 SHALL have port pout  output  WIDTH  last good frame's data word.
REQ-007 SHALL have port out_valid  output  1  pout holds an unconsumed word.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port overrun  output  1  sticky; a good frame was dropped because the previous word was still pending.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL use a frame of 1 start bit (1), then WIDTH data bits MSB first, then 1 stop bit (0), one bit per clk cycle.
REQ-012 SHALL implement the FSM IDLE, DATA, STOP; all outputs registered.
REQ-013 IDLE: sin=1 SHALL move the FSM to DATA and clear the bit counter; sin=0 SHALL keep it in IDLE.
REQ-014 DATA: each edge SHALL shift sin into the shift register LSB (shreg <= {shreg[WIDTH-2:0], sin}) and increment the counter.
REQ-015 DATA: on the edge that captures bit index WIDTH-1, the FSM SHALL move to STOP.
REQ-016 STOP with sin=0, out_valid=0 or out_ready=1: SHALL load pout <= shreg and set out_valid=1.
REQ-017 STOP with sin=0, out_valid=1 and out_ready=0: SHALL drop the new word, keep pout, and set overrun=1.
REQ-018 STOP with sin=1: SHALL discard the word, pulse frame_err for exactly one cycle, and leave pout, out_valid and overrun unchanged.
REQ-019 From STOP, the FSM SHALL always return to IDLE; the next start bit is accepted on the very next edge, so back-to-back frames need no gap.
REQ-020 out_valid=1 and out_ready=1 with no load that cycle SHALL clear out_valid on that edge.
REQ-021 Accept and a good-frame load in the same cycle SHALL leave out_valid=1 and pout=new word, with no overrun.
REQ-022 out_ready while out_valid=0 SHALL be ignored.
REQ-023 Latency: with the start bit sampled at edge N, out_valid SHALL be high after edge N+WIDTH+1.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits and never wrap within a frame.
REQ-025 overrun SHALL clear only on rst.
REQ-026 sin SHALL be ignored in STOP except as the stop bit; no resynchronisation mid-frame.

Reset
REQ-027 rst=1 at an edge SHALL force state=IDLE, counter=0, shreg=0, pout=0, out_valid=0, frame_err=0, overrun=0, busy=0, overriding all other inputs.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no output or error pulse; reception restarts on the first start bit after rst deasserts.

Verification (WIDTH=8)
REQ-029 SHALL cover: rst, then sin=1,1,0,1,0,0,1,0,1,0 with out_ready=0 -> pout=8'hA5 and out_valid=1 after the 10th edge; frame_err=0.
REQ-030 SHALL cover: the same frame but stop bit=1 -> frame_err high exactly one cycle; out_valid=0; pout=8'h00.
REQ-031 SHALL cover: frame 8'hA5 then back-to-back frame 8'h3C with out_ready=0 -> pout stays 8'hA5 and overrun=1 after the second stop bit.
REQ-032 SHALL cover: frame 8'hA5 pending, out_ready=1 exactly on the second frame's (8'h3C) stop cycle -> pout=8'h3C, out_valid=1, overrun=0.
REQ-033 SHALL cover: rst pulsed after 4 data bits, then a full frame 8'hFF -> only 8'hFF delivered; busy=0 in the cycle after rst.
REQ-034 SHALL cover: idle line (sin=0) for 20 cycles -> busy=0, out_valid=0 throughout.
